// File: rtl/rf_wport_arbiter.sv
// Register-file write-port arbiter: pipeline writeback has priority, long-latency results queue in a FIFO.
// Optional RF_WPORT_FWD_EN adds a combinational forwarding lookup over the FIFO and the rf_* stage.
module rf_wport_arbiter #(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wb_we,
    input  logic [4:0]  wb_waddr,
    input  logic [31:0] wb_wdata,
    input  logic [31:0] wb_pc,
    input  logic        lu_valid,
    output logic        lu_ready,
    input  logic [4:0]  lu_waddr,
    input  logic [31:0] lu_wdata,
    input  logic [31:0] lu_pc,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic [31:0] debug_wb_pc,
    output logic [3:0]  debug_wb_rf_wen,
    output logic        stall_req
`ifdef RF_WPORT_FWD_EN
    ,
    input  logic [4:0]  fwd_raddr,
    output logic        fwd_hit,
    output logic [31:0] fwd_data
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {IDLE, PEND, FORCE} state_t;

    logic [4:0]       addr_q [DEPTH];
    logic [31:0]      data_q [DEPTH];
    logic [31:0]      pc_q   [DEPTH];
    logic [DEPTH-1:0] vld_q, vld_d;
    logic [PW-1:0]    head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [3:0]       age_q, age_d;
    state_t           state_q, state_d;
    logic             rf_we_q, rf_we_d;
    logic [4:0]       rf_waddr_q, rf_waddr_d;
    logic [31:0]      rf_wdata_q, rf_wdata_d;
    logic [31:0]      rf_pc_q, rf_pc_d;
    logic             stall_q, stall_d;

    logic wb_act, nonempty, head_vld, skip, pop, full, push, go_force;

    assign full     = (cnt_q == CW'(DEPTH));
    assign lu_ready = !full;

    always_comb begin
        // A frozen pipeline (FORCE) cannot own the port, so its write is ignored.
        wb_act   = (state_q != FORCE) && wb_we && (wb_waddr != 5'd0);
        nonempty = (cnt_q != '0);
        head_vld = nonempty && vld_q[head_q];
        skip     = nonempty && !vld_q[head_q];
        pop      = head_vld && !wb_act;
        // A same-cycle pipeline write to the same register is younger; drop the unit result.
        push     = lu_valid && !full && (lu_waddr != 5'd0) && !(wb_act && lu_waddr == wb_waddr);
        go_force = (state_q == PEND) && wb_act && head_vld && (age_q >= 4'(STARVE_LIMIT));

        vld_d = vld_q;
        if (wb_act) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (vld_q[i] && addr_q[i] == wb_waddr) vld_d[i] = 1'b0;
            end
        end
        if (pop || skip) vld_d[head_q] = 1'b0;
        if (push) vld_d[tail_q] = 1'b1;

        head_d = head_q + PW'(pop || skip);
        tail_d = tail_q + PW'(push);
        cnt_d  = cnt_q - CW'(pop || skip) + CW'(push);

        if (!nonempty || pop || skip) age_d = 4'd0;
        else if (age_q != 4'd15)      age_d = age_q + 4'd1;
        else                          age_d = age_q;

        if (cnt_d == '0)   state_d = IDLE;
        else if (go_force) state_d = FORCE;
        else               state_d = PEND;
        stall_d = (state_d == FORCE);

        rf_we_d    = wb_act || pop;
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;
        rf_pc_d    = rf_pc_q;
        if (wb_act) begin
            rf_waddr_d = wb_waddr;
            rf_wdata_d = wb_wdata;
            rf_pc_d    = wb_pc;
        end else if (pop) begin
            rf_waddr_d = addr_q[head_q];
            rf_wdata_d = data_q[head_q];
            rf_pc_d    = pc_q[head_q];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_q      <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            cnt_q      <= '0;
            age_q      <= 4'd0;
            state_q    <= IDLE;
            stall_q    <= 1'b0;
            rf_we_q    <= 1'b0;
            rf_waddr_q <= 5'd0;
            rf_wdata_q <= 32'd0;
            rf_pc_q    <= 32'd0;
        end else begin
            vld_q      <= vld_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            cnt_q      <= cnt_d;
            age_q      <= age_d;
            state_q    <= state_d;
            stall_q    <= stall_d;
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
            rf_pc_q    <= rf_pc_d;
        end
    end

    // Payload storage needs no reset; occupancy is tracked by vld_q.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_q[tail_q] <= lu_waddr;
            data_q[tail_q] <= lu_wdata;
            pc_q[tail_q]   <= lu_pc;
        end
    end

    assign rf_we           = rf_we_q;
    assign rf_waddr        = rf_waddr_q;
    assign rf_wdata        = rf_wdata_q;
    assign debug_wb_pc     = rf_pc_q;
    assign debug_wb_rf_wen = {4{rf_we_q}};
    assign stall_req       = stall_q;

`ifdef RF_WPORT_FWD_EN
    logic [PW-1:0] fwd_idx;

    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = 32'd0;
        fwd_idx  = '0;
        // Walk head to tail so the youngest match is the one left standing.
        for (int k = 0; k < DEPTH; k++) begin
            fwd_idx = head_q + PW'(k);
            if (vld_q[fwd_idx] && addr_q[fwd_idx] == fwd_raddr) begin
                fwd_hit  = 1'b1;
                fwd_data = data_q[fwd_idx];
            end
        end
        if (rf_we_q && rf_waddr_q == fwd_raddr) begin
            fwd_hit  = 1'b1;
            fwd_data = rf_wdata_q;
        end
        if (fwd_raddr == 5'd0) begin
            fwd_hit  = 1'b0;
            fwd_data = 32'd0;
        end
    end
`endif

endmodule

// File: tb/tb_rf_wport_arbiter.sv
// Self-checking bench for rf_wport_arbiter (default build, RF_WPORT_FWD_EN undefined).
// Vector table, hand sequences for starvation and reset, then random traffic against a queue model.
module tb_rf_wport_arbiter;

    localparam int DEPTH = 2;
    localparam int LIMIT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        wb_we;
    logic [4:0]  wb_waddr;
    logic [31:0] wb_wdata, wb_pc;
    logic        lu_valid;
    logic        lu_ready;
    logic [4:0]  lu_waddr;
    logic [31:0] lu_wdata, lu_pc;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata, debug_wb_pc;
    logic [3:0]  debug_wb_rf_wen;
    logic        stall_req;

    int n_chk  = 0;
    int n_fail = 0;

    rf_wport_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .rst(rst),
        .wb_we(wb_we), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata), .wb_pc(wb_pc),
        .lu_valid(lu_valid), .lu_ready(lu_ready), .lu_waddr(lu_waddr),
        .lu_wdata(lu_wdata), .lu_pc(lu_pc),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .debug_wb_pc(debug_wb_pc), .debug_wb_rf_wen(debug_wb_rf_wen),
        .stall_req(stall_req)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        wb_we = 1'b0; wb_waddr = 5'd0; wb_wdata = 32'd0; wb_pc = 32'd0;
        lu_valid = 1'b0; lu_waddr = 5'd0; lu_wdata = 32'd0; lu_pc = 32'd0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [31:0] wp;
        logic        lv;
        logic [4:0]  la;
        logic [31:0] ld;
        logic [31:0] lp;
        logic        e_we;
        logic [4:0]  e_a;
        logic [31:0] e_d;
        logic [31:0] e_pc;
        logic        e_rdy;
        logic        e_st;
    } vec_t;

    vec_t tbl[11];

    // Reference model: a queue of pending unit results plus starvation bookkeeping.
    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
        logic [31:0] pc;
        bit          valid;
    } ent_t;

    ent_t        mq[$];
    int          m_age;
    bit          m_force;
    bit          m_we;
    logic [4:0]  m_a;
    logic [31:0] m_d, m_pc;

    task automatic model_reset();
        mq.delete();
        m_age = 0; m_force = 0; m_we = 0;
        m_a = 5'd0; m_d = 32'd0; m_pc = 32'd0;
    endtask

    task automatic model_step();
        bit   act, nonempty, hv, took, go, ready;
        ent_t e;
        act      = !m_force && wb_we && (wb_waddr != 5'd0);
        nonempty = mq.size() > 0;
        hv       = nonempty && mq[0].valid;
        ready    = mq.size() < DEPTH;
        took     = 0;
        m_we     = 0;
        if (act) begin
            m_we = 1; m_a = wb_waddr; m_d = wb_wdata; m_pc = wb_pc;
        end else if (hv) begin
            m_we = 1; m_a = mq[0].addr; m_d = mq[0].data; m_pc = mq[0].pc;
        end
        if (nonempty && (!mq[0].valid || !act)) begin
            void'(mq.pop_front());
            took = 1;
        end
        if (act) begin
            foreach (mq[i]) if (mq[i].addr == wb_waddr) mq[i].valid = 0;
        end
        go = !m_force && act && hv && (m_age >= LIMIT);
        if (lu_valid && ready && lu_waddr != 5'd0 && !(act && lu_waddr == wb_waddr)) begin
            e.addr = lu_waddr; e.data = lu_wdata; e.pc = lu_pc; e.valid = 1;
            mq.push_back(e);
        end
        if (!nonempty || took) m_age = 0;
        else if (m_age < 15)   m_age = m_age + 1;
        m_force = go && (mq.size() != 0);
    endtask

    initial begin
        idle_inputs();
        rst = 1'b0;
        #12;
        chk("reset rf_we", 32'(rf_we), 32'd0);
        chk("reset rf_waddr", 32'(rf_waddr), 32'd0);
        chk("reset rf_wdata", rf_wdata, 32'd0);
        chk("reset debug_wb_pc", debug_wb_pc, 32'd0);
        chk("reset debug_wb_rf_wen", 32'(debug_wb_rf_wen), 32'd0);
        chk("reset stall_req", 32'(stall_req), 32'd0);
        chk("reset lu_ready", 32'(lu_ready), 32'd1);
        @(posedge clk); #1;
        rst = 1'b1;

        //        we wa    wd          wp        lv la    ld     lp        e_we e_a  e_d         e_pc      rdy st
        tbl[0]  = '{1, 5'd5, 32'h1234, 32'h100, 0, 5'd0, 32'h0, 32'h0,   1, 5'd5, 32'h1234, 32'h100, 1, 0};
        tbl[1]  = '{0, 5'd0, 32'h0,    32'h0,   1, 5'd8, 32'hAA, 32'h200, 0, 5'd0, 32'h0,    32'h0,   1, 0};
        tbl[2]  = '{0, 5'd0, 32'h0,    32'h0,   0, 5'd0, 32'h0,  32'h0,   1, 5'd8, 32'hAA,   32'h200, 1, 0};
        tbl[3]  = '{0, 5'd0, 32'h0,    32'h0,   0, 5'd0, 32'h0,  32'h0,   0, 5'd0, 32'h0,    32'h0,   1, 0};
        tbl[4]  = '{0, 5'd0, 32'h0,    32'h0,   1, 5'd0, 32'h55, 32'h204, 0, 5'd0, 32'h0,    32'h0,   1, 0};
        tbl[5]  = '{0, 5'd0, 32'h0,    32'h0,   0, 5'd0, 32'h0,  32'h0,   0, 5'd0, 32'h0,    32'h0,   1, 0};
        tbl[6]  = '{1, 5'd0, 32'hDEAD, 32'h104, 0, 5'd0, 32'h0,  32'h0,   0, 5'd0, 32'h0,    32'h0,   1, 0};
        tbl[7]  = '{1, 5'd3, 32'h33,   32'h108, 1, 5'd9, 32'h1,  32'h208, 1, 5'd3, 32'h33,   32'h108, 1, 0};
        tbl[8]  = '{1, 5'd9, 32'h2,    32'h10C, 0, 5'd0, 32'h0,  32'h0,   1, 5'd9, 32'h2,    32'h10C, 1, 0};
        tbl[9]  = '{0, 5'd0, 32'h0,    32'h0,   0, 5'd0, 32'h0,  32'h0,   0, 5'd0, 32'h0,    32'h0,   1, 0};
        tbl[10] = '{0, 5'd0, 32'h0,    32'h0,   0, 5'd0, 32'h0,  32'h0,   0, 5'd0, 32'h0,    32'h0,   1, 0};

        for (int i = 0; i < 11; i++) begin
            wb_we = tbl[i].we; wb_waddr = tbl[i].wa; wb_wdata = tbl[i].wd; wb_pc = tbl[i].wp;
            lu_valid = tbl[i].lv; lu_waddr = tbl[i].la; lu_wdata = tbl[i].ld; lu_pc = tbl[i].lp;
            tick();
            chk($sformatf("vec%0d rf_we", i), 32'(rf_we), 32'(tbl[i].e_we));
            chk($sformatf("vec%0d wen", i), 32'(debug_wb_rf_wen), {28'd0, {4{tbl[i].e_we}}});
            if (tbl[i].e_we) begin
                chk($sformatf("vec%0d rf_waddr", i), 32'(rf_waddr), 32'(tbl[i].e_a));
                chk($sformatf("vec%0d rf_wdata", i), rf_wdata, tbl[i].e_d);
                chk($sformatf("vec%0d debug_pc", i), debug_wb_pc, tbl[i].e_pc);
            end
            chk($sformatf("vec%0d lu_ready", i), 32'(lu_ready), 32'(tbl[i].e_rdy));
            chk($sformatf("vec%0d stall", i), 32'(stall_req), 32'(tbl[i].e_st));
        end

        // Starvation: two queued results behind a pipeline that writes every cycle.
        for (int c = 0; c <= 12; c++) begin
            wb_we = 1'b1; wb_waddr = 5'(1 + c % 4); wb_wdata = 32'h3000 + 32'(c); wb_pc = 32'h400 + 32'(c * 4);
            lu_valid = (c < 2);
            lu_waddr = (c == 0) ? 5'd10 : 5'd11;
            lu_wdata = (c == 0) ? 32'hA0 : 32'hB0;
            lu_pc    = (c == 0) ? 32'h500 : 32'h504;
            tick();
            chk($sformatf("starve c%0d stall", c), 32'(stall_req), 32'(c == 5 || c == 11));
            chk($sformatf("starve c%0d rf_we", c), 32'(rf_we), 32'd1);
            if (c == 6) begin
                chk("starve head0 addr", 32'(rf_waddr), 32'd10);
                chk("starve head0 data", rf_wdata, 32'hA0);
            end else if (c == 12) begin
                chk("starve head1 addr", 32'(rf_waddr), 32'd11);
                chk("starve head1 pc", debug_wb_pc, 32'h504);
            end else begin
                chk($sformatf("starve c%0d addr", c), 32'(rf_waddr), 32'(1 + c % 4));
            end
            if (c == 1) chk("starve full lu_ready", 32'(lu_ready), 32'd0);
            if (c == 6) chk("starve after pop lu_ready", 32'(lu_ready), 32'd1);
        end
        idle_inputs();
        tick();
        chk("starve drained rf_we", 32'(rf_we), 32'd0);
        chk("starve drained lu_ready", 32'(lu_ready), 32'd1);

        // Reset with two results pending.
        for (int c = 0; c < 2; c++) begin
            wb_we = 1'b1; wb_waddr = 5'(20 + c); wb_wdata = 32'h7000; wb_pc = 32'h600;
            lu_valid = 1'b1; lu_waddr = 5'(12 + c); lu_wdata = 32'hC1 + 32'(c); lu_pc = 32'h700;
            tick();
        end
        chk("pre-reset lu_ready", 32'(lu_ready), 32'd0);
        idle_inputs();
        #2 rst = 1'b0;
        #1;
        chk("async rst rf_we", 32'(rf_we), 32'd0);
        chk("async rst rf_waddr", 32'(rf_waddr), 32'd0);
        chk("async rst rf_wdata", rf_wdata, 32'd0);
        chk("async rst lu_ready", 32'(lu_ready), 32'd1);
        chk("async rst stall", 32'(stall_req), 32'd0);
        tick();
        rst = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            chk($sformatf("post-rst idle%0d rf_we", c), 32'(rf_we), 32'd0);
        end

        // Random traffic against the queue model.
        model_reset();
        for (int c = 0; c < 3000; c++) begin
            wb_we    = ($urandom_range(0, 9) < (((c / 150) % 2 == 0) ? 8 : 3));
            wb_waddr = 5'($urandom_range(0, 5));
            wb_wdata = $urandom();
            wb_pc    = $urandom();
            lu_valid = ($urandom_range(0, 1) == 1);
            lu_waddr = 5'($urandom_range(0, 5));
            lu_wdata = $urandom();
            lu_pc    = $urandom();
            model_step();
            tick();
            chk("rnd rf_we", 32'(rf_we), 32'(m_we));
            if (m_we) begin
                chk("rnd rf_waddr", 32'(rf_waddr), 32'(m_a));
                chk("rnd rf_wdata", rf_wdata, m_d);
                chk("rnd debug_pc", debug_wb_pc, m_pc);
            end
            chk("rnd stall", 32'(stall_req), 32'(m_force));
            chk("rnd lu_ready", 32'(lu_ready), 32'(mq.size() < DEPTH));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
